// File: rtl/vram_arbiter.sv
// Display-priority arbiter sharing one single-port synchronous VRAM with a host command port.
// Optional stall counter: define VRAM_ARB_CONFLICT_CNT_EN to add conflict_cnt/conflict_clr.
module vram_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 3,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_CONFLICT_CNT_EN
    ,
    input  logic              conflict_clr,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, PENDING = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                hwe_q, hwe_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                gnt_disp, gnt_host;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                rd_vld_d, rd_host_d;
    logic [RAM_LAT:0]    rd_vld_q, rd_host_q;
    logic                disp_rvalid_q, host_rvalid_q;
    logic [DATA_W-1:0]   disp_rdata_q, host_rdata_q;

    always_comb begin
        state_d     = state_q;
        hwe_d       = hwe_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        host_ready  = (state_q == EMPTY);
        gnt_disp    = disp_req;
        gnt_host    = !disp_req && (state_q == PENDING);
        case (state_q)
            EMPTY: if (host_valid) begin
                state_d  = PENDING;
                hwe_d    = host_we;
                haddr_d  = host_addr;
                hwdata_d = host_wdata;
            end
            PENDING: if (gnt_host) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        ram_en_d    = gnt_disp || gnt_host;
        ram_we_d    = gnt_host && hwe_q;
        ram_addr_d  = gnt_disp ? disp_addr : (gnt_host ? haddr_q : '0);
        ram_wdata_d = ram_we_d ? hwdata_q : '0;
        rd_vld_d    = gnt_disp || (gnt_host && !hwe_q);
        rd_host_d   = gnt_host;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            hwe_q    <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hwe_q    <= hwe_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Owner tag rides alongside each read; the last stage lines up with valid ram_rdata.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q  <= '0;
            rd_host_q <= '0;
        end else begin
            rd_vld_q  <= {rd_vld_q[RAM_LAT-1:0], rd_vld_d};
            rd_host_q <= {rd_host_q[RAM_LAT-1:0], rd_host_d};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            disp_rvalid_q <= rd_vld_q[RAM_LAT] && !rd_host_q[RAM_LAT];
            host_rvalid_q <= rd_vld_q[RAM_LAT] && rd_host_q[RAM_LAT];
            if (rd_vld_q[RAM_LAT] && !rd_host_q[RAM_LAT]) disp_rdata_q <= ram_rdata;
            if (rd_vld_q[RAM_LAT] && rd_host_q[RAM_LAT])  host_rdata_q <= ram_rdata;
        end
    end

`ifdef VRAM_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            conflict_cnt_q <= '0;
        else if (conflict_clr)
            conflict_cnt_q <= '0;
        else if (state_q == PENDING && disp_req && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then random traffic, checked every cycle
// against a queue-based model of the arbitration rules and a behavioural RAM.
module tb_vram_arbiter;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 3;
    localparam int RAM_LAT = 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic              conflict_clr;
`ifdef VRAM_ARB_CONFLICT_CNT_EN
    logic [15:0]       conflict_cnt;
`endif

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_CONFLICT_CNT_EN
        , .conflict_clr(conflict_clr), .conflict_cnt(conflict_cnt)
`endif
    );

    always #10 clock = ~clock;

    // Behavioural single-port RAM with one clock read latency
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return DATA_W'((a * 5 + 1) ^ (a >> 3));
    endfunction

    typedef struct { int due; logic [DATA_W-1:0] data; } ret_t;
    typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } cmd_t;

    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    ret_t dq[$];
    ret_t hq[$];
    cmd_t hostq[$];
    int   ref_conf;
    int   cyc;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic d, input int da, input logic v, input logic we,
                         input int ha, input int wd);
        disp_req   = d;
        disp_addr  = ADDR_W'(da);
        host_valid = v;
        host_we    = we;
        host_addr  = ADDR_W'(ha);
        host_wdata = DATA_W'(wd);
    endtask

    // One clock: sample inputs, advance the model across the edge, compare all outputs.
    task automatic step();
        logic d, v, clr, was_empty, e_en, e_we, e_dv, e_hv;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_dd, e_hd;
        cmd_t c, nc;
        ret_t r;
        d = disp_req; v = host_valid; clr = conflict_clr;
        nc.we = host_we; nc.addr = host_addr; nc.wdata = host_wdata;
        c = nc;
        @(posedge clock);
        cyc++;
        #1;
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        e_dv = 0; e_hv = 0; e_dd = '0; e_hd = '0;
        if (!reset_n) begin
            dq.delete(); hq.delete(); hostq.delete(); ref_conf = 0;
        end else begin
            was_empty = (hostq.size() == 0);
            if (clr) ref_conf = 0;
            else if (!was_empty && d && ref_conf < 16'hFFFF) ref_conf++;
            if (d) begin
                e_en = 1; e_addr = disp_addr;
                r.due = cyc + RAM_LAT + 1; r.data = ref_mem[disp_addr];
                dq.push_back(r);
            end else if (!was_empty) begin
                c = hostq.pop_front();
                e_en = 1; e_we = c.we; e_addr = c.addr;
                if (c.we) begin
                    e_wdata = c.wdata;
                    ref_mem[c.addr] = c.wdata;
                end else begin
                    r.due = cyc + RAM_LAT + 1; r.data = ref_mem[c.addr];
                    hq.push_back(r);
                end
            end
            if (was_empty && v) hostq.push_back(nc);
            if (dq.size() > 0 && dq[0].due == cyc) begin
                r = dq.pop_front(); e_dv = 1; e_dd = r.data;
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                r = hq.pop_front(); e_hv = 1; e_hd = r.data;
            end
        end
        chk("ram_en", ram_en, e_en);
        if (e_en) begin
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
        end
        chk("host_ready", host_ready, hostq.size() == 0);
        chk("disp_rvalid", disp_rvalid, e_dv);
        if (e_dv) chk("disp_rdata", disp_rdata, e_dd);
        chk("host_rvalid", host_rvalid, e_hv);
        if (e_hv) chk("host_rdata", host_rdata, e_hd);
`ifdef VRAM_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", conflict_cnt, ref_conf);
`endif
    endtask

    initial begin
        int reads_left;
        logic prev_d;
        checks = 0; errors = 0; cyc = 0; ref_conf = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        conflict_clr = 0;
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 0;
        step(); step();
        reset_n = 1;
        for (int i = 0; i < 10; i++) step();

        // Host write then read of the same address
        drive(0, 0, 1, 1, 13'h0005, 6); step();
        drive(0, 0, 0, 0, 0, 0);        step(); step(); step();
        drive(0, 0, 1, 0, 13'h0005, 0); step();
        drive(0, 0, 0, 0, 0, 0);        for (int i = 0; i < 5; i++) step();

        // Alternating display fetches with four host reads in the gaps
        reads_left = 4;
        for (int i = 0; i < 16; i++) begin
            drive(i % 2 == 0, i / 2, hostq.size() == 0 && reads_left > 0, 0, 13'h0100 + i, 0);
            if (hostq.size() == 0 && reads_left > 0) reads_left--;
            step();
        end
        drive(0, 0, 0, 0, 0, 0); for (int i = 0; i < 6; i++) step();

        // Display held high while a host write waits
        drive(0, 0, 1, 1, 13'h0020, 3); step();
        for (int i = 0; i < 20; i++) begin
            drive(1, 13'h0040 + i, 0, 0, 0, 0); step();
        end
`ifdef VRAM_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt_20", conflict_cnt, 20);
`endif
        drive(0, 0, 0, 0, 0, 0); for (int i = 0; i < 4; i++) step();
        conflict_clr = 1; step();
        conflict_clr = 0; step();

        // Reset one cycle after a display issue, with a host command pending
        drive(0, 0, 1, 0, 13'h0020, 0); step();
        drive(1, 13'h0003, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 0;
        step(); step();
        reset_n = 1;
        for (int i = 0; i < 6; i++) step();
        chk("ready_after_reset", host_ready, 1'b1);

        // Random traffic obeying the every-other-cycle display contract
        prev_d = 0;
        for (int i = 0; i < 500; i++) begin
            drive(!prev_d && $urandom_range(0, 2) != 0, $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  13'h1000 + $urandom_range(0, 15), $urandom_range(0, 7));
            prev_d = disp_req;
            conflict_clr = ($urandom_range(0, 63) == 0);
            step();
        end
        conflict_clr = 0;
        drive(0, 0, 0, 0, 0, 0); for (int i = 0; i < 6; i++) step();
        chk("disp_queue_drained", dq.size(), 0);
        chk("host_queue_drained", hq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
